// File: rtl/fetch_stage.sv
// Instruction fetch stage: 256-byte byte-addressed instruction memory, PC, and the
// IF/ID register, sequenced by an IDLE/RUN/HALT controller.
module fetch_stage #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [3:0] HALT_OP  = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [7:0]  branch_target,
   input  logic        imem_we,
   input  logic [7:0]  imem_addr,
   input  logic [7:0]  imem_wdata,
   output logic [31:0] instr,
   output logic [7:0]  pc_out,
   output logic [3:0]  rs,
   output logic [3:0]  rt,
   output logic [3:0]  rd,
   output logic        valid,
   output logic        halted,
   output logic [1:0]  dbg_state
);

   // Handshake: there is no backpressure on the output side; valid qualifies
   // instr/pc_out every cycle, and stall is the only hold request from downstream.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  pc, pc_nxt;
   logic [31:0] instr_nxt;
   logic [7:0]  pc_out_nxt;
   logic        valid_nxt;

   logic [7:0]  mem [256];
   logic [7:0]  addr1, addr2, addr3;
   logic [31:0] fetch_word;
   logic [7:0]  redirect_pc;
   logic        unused_target_lsbs;

   // Memory has no reset so its contents survive rst_n; reads are combinational,
   // so a fetch on a write edge naturally sees the old byte.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
      end
   end

   assign addr1       = pc + 8'd1;
   assign addr2       = pc + 8'd2;
   assign addr3       = pc + 8'd3;
   assign fetch_word  = {mem[pc], mem[addr1], mem[addr2], mem[addr3]};
   assign redirect_pc = {branch_target[7:2], 2'b00};
   assign unused_target_lsbs = ^branch_target[1:0];

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      instr_nxt  = instr;
      pc_out_nxt = pc_out;
      valid_nxt  = valid;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (branch_taken) begin
               pc_nxt    = redirect_pc;
               instr_nxt = 32'h0;
               valid_nxt = 1'b0;
            end else if (!stall) begin
               instr_nxt  = fetch_word;
               pc_out_nxt = pc;
               valid_nxt  = 1'b1;
               pc_nxt     = pc + 8'd4;
               if (fetch_word[31:28] == HALT_OP) begin
                  state_nxt = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            // The halt word stays visible until the first unstalled cycle in HALT.
            if (branch_taken) begin
               state_nxt = ST_RUN;
               pc_nxt    = redirect_pc;
               instr_nxt = 32'h0;
               valid_nxt = 1'b0;
            end else if (!stall) begin
               valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         pc     <= RESET_PC;
         instr  <= 32'h0;
         pc_out <= 8'h00;
         valid  <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         instr  <= instr_nxt;
         pc_out <= pc_out_nxt;
         valid  <= valid_nxt;
         halted <= (state_nxt == ST_HALT);
      end
   end

   assign rs        = instr[27:24];
   assign rt        = instr[23:20];
   assign rd        = instr[19:16];
   assign dbg_state = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a behavioural fetch model,
// plus a second instance with RESET_PC=8'hFC for the address wrap-around case.
module tb_fetch_stage;
   localparam logic [3:0] HALT_OP = 4'hF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, stall, branch_taken, imem_we;
   logic [7:0]  branch_target, imem_addr, imem_wdata;
   logic [31:0] instr;
   logic [7:0]  pc_out;
   logic [3:0]  rs, rt, rd;
   logic        valid, halted;
   logic [1:0]  dbg_state;

   logic        rst2_n, start2, zero2, we2;
   logic [7:0]  addr2, wdata2, target2;
   logic [31:0] instr2;
   logic [7:0]  pc_out2;
   logic [3:0]  rs2, rt2, rd2;
   logic        valid2, halted2;
   logic [1:0]  dbg_state2;

   fetch_stage #(.RESET_PC(8'h00), .HALT_OP(HALT_OP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .instr(instr), .pc_out(pc_out), .rs(rs), .rt(rt), .rd(rd),
      .valid(valid), .halted(halted), .dbg_state(dbg_state)
   );

   fetch_stage #(.RESET_PC(8'hFC), .HALT_OP(HALT_OP)) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .start(start2), .stall(zero2),
      .branch_taken(zero2), .branch_target(target2),
      .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
      .instr(instr2), .pc_out(pc_out2), .rs(rs2), .rt(rt2), .rd(rd2),
      .valid(valid2), .halted(halted2), .dbg_state(dbg_state2)
   );

   // ---------------- scoreboard / reference model ----------------
   int errors = 0;
   int checks = 0;

   logic [7:0]  mm [256];
   logic [7:0]  m_pc, m_pc_out;
   logic [31:0] m_instr;
   logic        m_valid;
   bit          m_running, m_halted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_pc      = 8'h00;
      m_pc_out  = 8'h00;
      m_instr   = 32'h0;
      m_valid   = 1'b0;
      m_running = 1'b0;
      m_halted  = 1'b0;
   endfunction

   // One clock edge of the fetch stage as seen from outside, from the current inputs.
   function automatic void model_step();
      logic [7:0]  a1, a2, a3;
      logic [31:0] word;
      a1   = m_pc + 8'd1;
      a2   = m_pc + 8'd2;
      a3   = m_pc + 8'd3;
      word = {mm[m_pc], mm[a1], mm[a2], mm[a3]};
      if (!m_running && !m_halted) begin
         if (start) m_running = 1'b1;
      end else if (branch_taken) begin
         m_pc      = {branch_target[7:2], 2'b00};
         m_valid   = 1'b0;
         m_instr   = 32'h0;
         m_running = 1'b1;
         m_halted  = 1'b0;
      end else if (stall) begin
         // everything holds
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else begin
         m_instr  = word;
         m_pc_out = m_pc;
         m_valid  = 1'b1;
         m_pc     = m_pc + 8'd4;
         if (word[31:28] == HALT_OP) begin
            m_halted  = 1'b1;
            m_running = 1'b0;
         end
      end
      if (imem_we) mm[imem_addr] = imem_wdata;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_instr"},  instr,  m_instr);
      chk({tag, "_pc_out"}, pc_out, m_pc_out);
      chk({tag, "_valid"},  valid,  m_valid);
      chk({tag, "_halted"}, halted, m_halted);
      chk({tag, "_rs"},     rs,     m_instr[27:24]);
      chk({tag, "_rt"},     rt,     m_instr[23:20]);
      chk({tag, "_rd"},     rd,     m_instr[19:16]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cycle_chk(input string tag);
      cycle();
      check_all(tag);
   endtask

   task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
      imem_we    = 1'b1;
      imem_addr  = a;
      imem_wdata = d;
      cycle();
      imem_we    = 1'b0;
   endtask

   // Asserts reset mid-cycle, checks the asynchronous effect, releases on a negedge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all({tag, "_async"});
      chk({tag, "_instr0"}, instr, 32'h0);
      chk({tag, "_valid0"}, valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check_all({tag, "_hold"});
      rst_n = 1'b1;
   endtask

   task automatic wrap_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] b;
      logic [7:0] pat [8];
      pat = '{8'hD1, 8'h18, 8'hD1, 8'h18, 8'h18, 8'hD1, 8'h18, 8'h18};
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      imem_we = 1'b0; branch_target = 8'h00; imem_addr = 8'h00; imem_wdata = 8'h00;
      rst2_n = 1'b0; start2 = 1'b0; zero2 = 1'b0; we2 = 1'b0;
      addr2 = 8'h00; wdata2 = 8'h00; target2 = 8'h00;
      model_reset();
      #2;
      check_all("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Fill memory; word-leading bytes avoid the halt opcode.
      for (int a = 0; a < 256; a++) begin
         b = 8'($urandom_range(0, 255));
         if ((a % 4) == 0 && b[7:4] == HALT_OP) b[7:4] = 4'h7;
         write_byte(8'(a), b);
      end
      for (int a = 0; a < 8; a++) write_byte(8'(a), pat[a]);
      do_reset("rst1");

      // Start and first two fetches.
      start = 1'b1;
      cycle_chk("start_edge");
      chk("start_edge_valid", valid, 1'b0);
      start = 1'b0;
      cycle_chk("fetch0");
      chk("fetch0_word", instr, 32'hD118D118);
      chk("fetch0_pc", pc_out, 8'h00);
      chk("fetch0_valid", valid, 1'b1);
      cycle_chk("fetch4");
      chk("fetch4_word", instr, 32'h18D11818);
      chk("fetch4_pc", pc_out, 8'h04);
      chk("fetch4_valid", valid, 1'b1);

      // Stall for 3 cycles at pc=8.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle_chk("stall");
         chk("stall_word", instr, 32'h18D11818);
         chk("stall_pc", pc_out, 8'h04);
         chk("stall_valid", valid, 1'b1);
      end
      stall = 1'b0;
      cycle_chk("resume");
      chk("resume_pc", pc_out, 8'h08);

      // Branch overrides stall; target low bits ignored.
      branch_taken = 1'b1; stall = 1'b1; branch_target = 8'h23;
      cycle_chk("br_stall");
      chk("br_stall_valid", valid, 1'b0);
      chk("br_stall_instr", instr, 32'h0);
      branch_taken = 1'b0; stall = 1'b0;
      cycle_chk("br_fetch");
      chk("br_fetch_pc", pc_out, 8'h20);

      // Halt word at 0x0C.
      stall = 1'b1;
      write_byte(8'h0C, 8'hF0);
      write_byte(8'h0D, 8'h00);
      write_byte(8'h0E, 8'h00);
      write_byte(8'h0F, 8'h00);
      stall = 1'b0;
      branch_taken = 1'b1; branch_target = 8'h0C;
      cycle_chk("br_halt");
      branch_taken = 1'b0;
      cycle_chk("halt_word");
      chk("halt_word_instr", instr, 32'hF0000000);
      chk("halt_word_valid", valid, 1'b1);
      chk("halt_word_halted", halted, 1'b1);
      cycle_chk("halt_rest");
      chk("halt_rest_valid", valid, 1'b0);
      chk("halt_rest_halted", halted, 1'b1);
      start = 1'b1;
      cycle_chk("halt_start");
      chk("halt_start_halted", halted, 1'b1);
      start = 1'b0;
      branch_taken = 1'b1; branch_target = 8'h00;
      cycle_chk("halt_exit");
      chk("halt_exit_halted", halted, 1'b0);
      branch_taken = 1'b0;
      cycle_chk("refetch0");
      chk("refetch0_word", instr, 32'hD118D118);
      chk("refetch0_pc", pc_out, 8'h00);

      // Write on the same edge that fetches address 4.
      imem_we = 1'b1; imem_addr = 8'h04; imem_wdata = 8'hAB;
      cycle_chk("wr_same_edge");
      chk("wr_same_edge_word", instr, 32'h18D11818);
      imem_we = 1'b0;
      branch_taken = 1'b1; branch_target = 8'h04;
      cycle_chk("br4");
      branch_taken = 1'b0;
      cycle_chk("refetch4");
      chk("refetch4_msb", {24'h0, instr[31:24]}, 32'h000000AB);

      // Stall on the first HALT edge keeps the halt word valid.
      branch_taken = 1'b1; branch_target = 8'h0C;
      cycle_chk("br_halt2");
      branch_taken = 1'b0;
      cycle_chk("halt2_word");
      stall = 1'b1;
      cycle_chk("halt2_stall");
      chk("halt2_stall_valid", valid, 1'b1);
      stall = 1'b0;
      cycle_chk("halt2_unstall");
      chk("halt2_unstall_valid", valid, 1'b0);
      branch_taken = 1'b1; branch_target = 8'h10;
      cycle_chk("halt2_exit");
      branch_taken = 1'b0;

      // Reset in the middle of a stall, then start on the release edge.
      cycle_chk("pre_rst");
      stall = 1'b1;
      cycle_chk("pre_rst_stall");
      do_reset("rst2");
      stall = 1'b0;
      start = 1'b1;
      cycle_chk("post_rst_start");
      start = 1'b0;
      cycle_chk("post_rst_fetch");
      chk("post_rst_pc", pc_out, 8'h00);
      chk("post_rst_word", instr, 32'hD118D118);

      // Randomized phase.
      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom_range(0, 3) == 0);
         branch_taken  = ($urandom_range(0, 9) == 0);
         branch_target = 8'($urandom_range(0, 255));
         start         = ($urandom_range(0, 7) == 0);
         imem_we       = ($urandom_range(0, 4) == 0);
         imem_addr     = 8'($urandom_range(0, 255));
         imem_wdata    = 8'($urandom_range(0, 255));
         cycle_chk("rand");
      end
      stall = 1'b0; branch_taken = 1'b0; start = 1'b0; imem_we = 1'b0;

      // Wrap-around instance: RESET_PC=8'hFC.
      chk("wrap_rst_instr", instr2, 32'h0);
      chk("wrap_rst_pc", pc_out2, 8'h00);
      for (int i = 0; i < 8; i++) begin
         we2    = 1'b1;
         addr2  = 8'hFC + 8'(i);
         wdata2 = 8'h11 * 8'(i + 1);
         wrap_cycle();
      end
      we2 = 1'b0;
      rst2_n = 1'b1;
      start2 = 1'b1;
      wrap_cycle();
      start2 = 1'b0;
      wrap_cycle();
      chk("wrap_w0", instr2, 32'h11223344);
      chk("wrap_w0_pc", pc_out2, 8'hFC);
      chk("wrap_w0_valid", valid2, 1'b1);
      wrap_cycle();
      chk("wrap_w1", instr2, 32'h55667788);
      chk("wrap_w1_pc", pc_out2, 8'h00);
      chk("wrap_w1_halted", halted2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
